// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: synchronizes rxd, samples each bit mid-period and
// hands completed bytes to the consumer through a data_valid/data_ack handshake.
module uart_byte_rx #(
  parameter int unsigned cycle_BRG = 10416,
  parameter int unsigned half_BRG  = cycle_BRG / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       data_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CNT_W  = 14;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic [DATA_W-1:0]   data_out_nxt;
  logic                data_valid_nxt, frame_err_nxt, overrun_nxt;
  logic                rx_meta, rx_s, rx_d;

  // State and datapath registers; synchronizer flops reset to the idle level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      shreg      <= shreg_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      frame_err  <= frame_err_nxt;
      overrun    <= overrun_nxt;
      busy       <= (state_nxt != IDLE);
      rx_meta    <= rxd;
      rx_s       <= rx_meta;
      rx_d       <= rx_s;
    end
  end

  // Next-state and output logic; a good-byte load in STOP overrides the ack.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + CNT_W'(1);
    idx_nxt        = idx;
    shreg_nxt      = shreg;
    data_out_nxt   = data_out;
    data_valid_nxt = data_valid;
    frame_err_nxt  = 1'b0;
    overrun_nxt    = overrun;

    if (data_ack && data_valid) begin
      data_valid_nxt = 1'b0;
      overrun_nxt    = 1'b0;
    end

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rx_d && !rx_s) begin
          state_nxt = START;
        end
      end
      START: begin
        if (cnt == CNT_W'(half_BRG)) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt = DATA;
            idx_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == CNT_W'(cycle_BRG)) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s, shreg[DATA_W-1:1]};
          idx_nxt   = idx + IDX_W'(1);
          if (idx == IDX_W'(DATA_W - 1)) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (cnt == CNT_W'(cycle_BRG)) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (rx_s) begin
            data_out_nxt   = shreg;
            data_valid_nxt = 1'b1;
            if (data_valid && !data_ack) begin
              overrun_nxt = 1'b1;
            end
          end else begin
            frame_err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Receives one 8N1 UART frame at a time from a serial line and presents each byte on a parallel output with a valid/acknowledge handshake. It is the receive-side counterpart of the byte transmitter and uses the same bit-period convention, so a transmitter's Txd can be looped directly into this block's rxd. Received bytes feed downstream logic such as a command decoder or a FIFO. Framing errors and overruns are flagged.

## Interface
- cycle_BRG, 10416, bit period is cycle_BRG+1 clocks; 10416 gives 9600 baud at 100 MHz.
- half_BRG, cycle_BRG/2 (integer division), counter value at which the start bit is re-checked (mid-bit).
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- rxd  input  1  asynchronous serial line; idles high.
- data_ack  input  1  consumer acknowledge; clears data_valid.
- data_out  output  8  last good byte, LSB received first; holds its value until the next good byte.
- data_valid  output  1  high while data_out holds an unacknowledged byte.
- frame_err  output  1  one-clock pulse when a stop bit samples low.
- overrun  output  1  sticky; set when a good byte overwrites an unacknowledged one.
- busy  output  1  high in every state except IDLE.

## Operation
- rxd passes through a 2-flop synchronizer to produce rx_s, plus one more register rx_d used for edge detection. Reset values are 1.
- Bit counter: 14 bits, and it must hold cycle_BRG. It resets to 0 on every state entry. Sampling occurs at the compare value; the counter then returns to 0.
- The data shift register is 8 bits. Each sampled bit enters at bit 7 while the register shifts right, so the first bit received ends in bit 0.
- Bit index: 3 bits, counting data bits 0..7.
- IDLE:
  - A falling edge (rx_d=1, rx_s=0) moves the block to START with the counter at 0.
  - A line held low does not retrigger; a new start requires a 1→0 transition.
- START:
  - At counter==half_BRG, sample rx_s.
  - If rx_s=0, move to DATA and clear the counter and bit index.
  - If rx_s=1, treat it as a glitch and return to IDLE with no flags.
- DATA:
  - At counter==cycle_BRG, shift rx_s in and increment the bit index.
  - After the 8th sample, move to STOP.
- STOP: at counter==cycle_BRG, sample rx_s and return to IDLE.
  - If rx_s=1 (good byte): load data_out with the shift register and set data_valid=1. If data_valid was already 1 and data_ack is 0 this cycle, also set overrun=1.
  - If rx_s=0: pulse frame_err for one cycle. data_out, data_valid and overrun are unchanged.
- Handshake:
  - data_ack=1 while data_valid=1 clears data_valid and overrun on the next edge.
  - data_ack while data_valid=0 has no effect.
  - If data_ack and a good-byte load occur in the same cycle, the load wins: data_valid stays 1, data_out takes the new byte, overrun is not set, and any existing overrun is cleared.
- Reset (asserted at any time, including mid-frame): state=IDLE, counters=0, shift register=0, data_out=8'h00, data_valid=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1.

## Timing
- Start-bit edge to START entry: 3 clocks (2 synchronizer flops plus the edge register).
- Start re-check: half_BRG clocks after START entry.
- Data bit n (n=0..7) is sampled (n+1)·(cycle_BRG+1) clocks after the start check, i.e. mid-bit. The stop bit is sampled 9·(cycle_BRG+1) clocks after the start check.
- data_valid and frame_err assert on the same edge that samples the stop bit. The next start edge can be detected in the following cycle.
- busy rises on START entry and falls on the edge that returns the block to IDLE.
- Back-to-back frames with no idle gap are received without loss, because the stop bit is sampled mid-bit.

## Test plan
- Use cycle_BRG=15 throughout. Send 8'hA5 with correct framing, then pulse data_ack → data_out=8'hA5, data_valid=1 until ack, frame_err=0, overrun=0.
- Low pulse of 3 clocks on an idle line → block returns to IDLE after the half_BRG check; data_valid, frame_err and overrun stay 0; busy pulses.
- Send 8'h3C with the stop bit driven 0 → frame_err pulses for exactly 1 clock; data_valid=0. Holding rxd low afterwards does not restart reception until the line returns high and falls again.
- Send 8'h01 then 8'hFE back-to-back without ack → data_out=8'hFE, data_valid=1, overrun=1. After data_ack, both flags clear. Repeat with data_ack coincident with the second stop sample → overrun=0, data_valid=1, data_out=8'hFE.
- Assert rst in the middle of bit 4 of a frame, then release → all outputs at reset values, busy=0. A subsequent full frame of 8'h5A is received correctly.
- Loop a byte transmitter's Txd into rxd for 8'h00, 8'hFF, 8'h55 with matching cycle_BRG → each byte is received exactly, with no errors.
